// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage vs. one device requester, with
// anti-starvation for the device. Optional perf counters under DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall_mem,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_gnt,
  output logic              dev_done,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_dev_grants
`endif
);

  localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DEV} state_e;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dev_rdata_q, dev_rdata_d;

  logic completing, cpu_complete, dev_complete, grant_cpu, grant_dev;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign completing   = (state_q != IDLE) && (lat_cnt_q == LAT_W'(1));
  assign cpu_complete = (state_q == BUSY_CPU) && completing;
  assign dev_complete = (state_q == BUSY_DEV) && completing;
  assign grant_cpu    = rst_n && (state_q == IDLE) && cpu_req &&
                        !(dev_req && (starve_cnt_q == STV_LIM));
  assign grant_dev    = rst_n && (state_q == IDLE) && dev_req && !grant_cpu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      cpu_rdata_q  <= '0;
      dev_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dev_rdata_q  <= dev_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dev_rdata_d  = dev_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          state_d   = BUSY_CPU;
          lat_cnt_d = LAT_INIT;
          if (dev_req && (starve_cnt_q != STV_LIM))
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end else if (grant_dev) begin
          state_d      = BUSY_DEV;
          lat_cnt_d    = LAT_INIT;
          starve_cnt_d = '0;
        end else if (!dev_req) begin
          starve_cnt_d = '0;
        end
      end
      BUSY_CPU, BUSY_DEV: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (completing) begin
          state_d = IDLE;
          if (state_q == BUSY_CPU) cpu_rdata_d = mem_rdata;
          else                     dev_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The completion cycle bypasses memory data straight to the CPU.
  always_comb begin
    mem_en    = grant_cpu | grant_dev;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grant_dev) begin
      mem_we    = dev_we;
      mem_addr  = dev_addr;
      mem_wdata = dev_wdata;
    end
    dev_gnt   = grant_dev;
    dev_done  = dev_complete;
    dev_rdata = dev_rdata_q;
    cpu_rdata = cpu_complete ? mem_rdata : cpu_rdata_q;
    stall_mem = rst_n && cpu_req && !cpu_complete;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_gnt_q, perf_gnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_gnt_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_gnt_q   <= perf_gnt_d;
    end
  end

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_gnt_d   = perf_gnt_q;
    if (stall_mem && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
    if (dev_gnt && (perf_gnt_q != 32'hFFFF_FFFF))     perf_gnt_d   = perf_gnt_q + 32'd1;
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_dev_grants   = perf_gnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: default instance (MEM_LAT=2, STARVE_MAX=4)
// plus a MEM_LAT=1 instance; perf counters checked when DMEM_ARB_PERF_EN is set.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req, cpu_we, dev_req, dev_we;
  logic [31:0] cpu_addr, cpu_wdata, dev_addr, dev_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dev_rdata, mem_addr, mem_wdata;
  logic        stall_mem, dev_gnt, dev_done, mem_en, mem_we;

  logic        cpu1_req;
  logic [31:0] cpu1_addr, mem1_rdata, cpu1_rdata, dev1_rdata, mem1_addr, mem1_wdata;
  logic        stall1, dev1_gnt, dev1_done, mem1_en, mem1_we;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall, perf_gnt, perf1_stall, perf1_gnt;
`endif

  int total = 0;
  int bad   = 0;

  dmem_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall_mem(stall_mem),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_gnt(dev_gnt), .dev_done(dev_done), .dev_rdata(dev_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall), .perf_dev_grants(perf_gnt)
`endif
  );

  dmem_arbiter #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu1_req), .cpu_we(zero1), .cpu_addr(cpu1_addr), .cpu_wdata(zero32),
    .cpu_rdata(cpu1_rdata), .stall_mem(stall1),
    .dev_req(zero1), .dev_we(zero1), .dev_addr(zero32), .dev_wdata(zero32),
    .dev_gnt(dev1_gnt), .dev_done(dev1_done), .dev_rdata(dev1_rdata),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_rdata(mem1_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cycles(perf1_stall), .perf_dev_grants(perf1_gnt)
`endif
  );

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
    dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h20; dev_wdata = '0;
    mem_rdata = '0; cpu1_req = 1'b0; cpu1_addr = '0; mem1_rdata = '0;
    next_cycle; next_cycle; sample;
    total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_en: got %b want 0", mem_en); end
    total++; if (stall_mem !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", stall_mem); end
    total++; if (dev_gnt !== 1'b0 || dev_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_dev_pulses: got gnt=%b done=%b want 0 0", dev_gnt, dev_done); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    total++; if (dev_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_dev_rdata: got %h want 0", dev_rdata); end
    next_cycle;
    cpu_req = 1'b0; dev_req = 1'b0; rst_n = 1'b1;
    sample;
    total++; if (mem_en !== 1'b0 || stall_mem !== 1'b0) begin bad++; $display("[TB] FAIL idle_quiet: got en=%b stall=%b want 0 0", mem_en, stall_mem); end
  endtask

  task automatic test_cpu_load;
    next_cycle;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    sample;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin bad++; $display("[TB] FAIL load_issue: got en=%b we=%b addr=%h want 1 0 00000100", mem_en, mem_we, mem_addr); end
    total++; if (stall_mem !== 1'b1) begin bad++; $display("[TB] FAIL load_stall_c0: got %b want 1", stall_mem); end
    next_cycle; sample;
    total++; if (mem_en !== 1'b0 || stall_mem !== 1'b1) begin bad++; $display("[TB] FAIL load_c1: got en=%b stall=%b want 0 1", mem_en, stall_mem); end
    next_cycle;
    mem_rdata = 32'hDEADBEEF;
    sample;
    total++; if (stall_mem !== 1'b0) begin bad++; $display("[TB] FAIL load_stall_c2: got %b want 0", stall_mem); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_bypass: got %h want deadbeef", cpu_rdata); end
    next_cycle;
    cpu_req = 1'b0; mem_rdata = '0;
    sample;
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_hold: got %h want deadbeef", cpu_rdata); end
    total++; if (mem_en !== 1'b0 || stall_mem !== 1'b0) begin bad++; $display("[TB] FAIL load_after: got en=%b stall=%b want 0 0", mem_en, stall_mem); end
  endtask

  task automatic test_cpu_store;
    int en_cnt, stall_cnt;
    en_cnt = 0; stall_cnt = 0;
    next_cycle;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      sample;
      if (mem_en === 1'b1) en_cnt++;
      if (stall_mem === 1'b1) stall_cnt++;
      if (i == 0) begin
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin bad++; $display("[TB] FAIL store_fields: got we=%b addr=%h data=%h want 1 00000040 12345678", mem_we, mem_addr, mem_wdata); end
      end
      next_cycle;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    total++; if (en_cnt != 1) begin bad++; $display("[TB] FAIL store_en_count: got %0d want 1", en_cnt); end
    total++; if (stall_cnt != 2) begin bad++; $display("[TB] FAIL store_stall_count: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_simultaneous;
    next_cycle;
    cpu_req = 1'b1; cpu_addr = 32'h200;
    dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h300;
    sample;
    total++; if (mem_en !== 1'b1 || mem_addr !== 32'h200 || dev_gnt !== 1'b0) begin bad++; $display("[TB] FAIL sim_cpu_wins: got en=%b addr=%h gnt=%b want 1 00000200 0", mem_en, mem_addr, dev_gnt); end
    next_cycle; next_cycle;
    mem_rdata = 32'h11112222;
    sample;
    total++; if (stall_mem !== 1'b0 || cpu_rdata !== 32'h11112222) begin bad++; $display("[TB] FAIL sim_cpu_done: got stall=%b rdata=%h want 0 11112222", stall_mem, cpu_rdata); end
    next_cycle;
    cpu_req = 1'b0; mem_rdata = '0;
    sample;
    total++; if (dev_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL sim_dev_gnt: got gnt=%b en=%b addr=%h we=%b want 1 1 00000300 0", dev_gnt, mem_en, mem_addr, mem_we); end
    next_cycle; sample;
    total++; if (dev_gnt !== 1'b0 || dev_done !== 1'b0) begin bad++; $display("[TB] FAIL sim_dev_busy: got gnt=%b done=%b want 0 0", dev_gnt, dev_done); end
    next_cycle;
    mem_rdata = 32'hA5A5A5A5;
    sample;
    total++; if (dev_done !== 1'b1) begin bad++; $display("[TB] FAIL sim_dev_done: got %b want 1", dev_done); end
    next_cycle;
    dev_req = 1'b0; mem_rdata = '0;
    sample;
    total++; if (dev_done !== 1'b0 || dev_rdata !== 32'hA5A5A5A5) begin bad++; $display("[TB] FAIL sim_dev_rdata: got done=%b rdata=%h want 0 a5a5a5a5", dev_done, dev_rdata); end
  endtask

  // Four CPU grants with the device waiting; the fifth must go to the device.
  task automatic test_starvation;
    logic exp_dev;
    next_cycle;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500;
    dev_req = 1'b1; dev_we = 1'b1; dev_addr = 32'h600; dev_wdata = 32'h0BADF00D;
    mem_rdata = 32'h77;
    for (int g = 0; g < 6; g++) begin
      exp_dev = (g == 4);
      sample;
      total++;
      if (dev_gnt !== exp_dev || mem_en !== 1'b1 || mem_we !== exp_dev ||
          mem_addr !== (exp_dev ? 32'h600 : 32'h500)) begin
        bad++; $display("[TB] FAIL starve_grant%0d: got gnt=%b en=%b we=%b addr=%h want gnt=%b", g, dev_gnt, mem_en, mem_we, mem_addr, exp_dev);
      end
      next_cycle; next_cycle; sample;
      total++;
      if (exp_dev ? (dev_done !== 1'b1 || stall_mem !== 1'b1) : (dev_done !== 1'b0 || stall_mem !== 1'b0)) begin
        bad++; $display("[TB] FAIL starve_complete%0d: got done=%b stall=%b want done=%b stall=%b", g, dev_done, stall_mem, exp_dev, exp_dev);
      end
      next_cycle;
    end
    cpu_req = 1'b0; dev_req = 1'b0; dev_we = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset_mid;
    int done_seen;
    done_seen = 0;
    next_cycle;
    dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h700;
    sample;
    total++; if (dev_gnt !== 1'b1) begin bad++; $display("[TB] FAIL rmid_gnt: got %b want 1", dev_gnt); end
    next_cycle;
    rst_n = 1'b0;
    #1;
    total++; if (mem_en !== 1'b0 || dev_gnt !== 1'b0 || dev_done !== 1'b0 || stall_mem !== 1'b0) begin bad++; $display("[TB] FAIL rmid_outputs: got en=%b gnt=%b done=%b stall=%b want 0 0 0 0", mem_en, dev_gnt, dev_done, stall_mem); end
    total++; if (dev_rdata !== 32'h0 || cpu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rmid_rdata: got dev=%h cpu=%h want 0 0", dev_rdata, cpu_rdata); end
    next_cycle;
    dev_req = 1'b0;
    next_cycle;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample;
      if (dev_done === 1'b1 || mem_en === 1'b1) done_seen++;
      next_cycle;
    end
    total++; if (done_seen != 0) begin bad++; $display("[TB] FAIL rmid_no_done: got %0d activity cycles want 0", done_seen); end
    dev_req = 1'b1; dev_addr = 32'h710;
    sample;
    total++; if (dev_gnt !== 1'b1 || mem_addr !== 32'h710) begin bad++; $display("[TB] FAIL rmid_regrant: got gnt=%b addr=%h want 1 00000710", dev_gnt, mem_addr); end
    next_cycle; next_cycle;
    mem_rdata = 32'h3C3C3C3C;
    sample;
    total++; if (dev_done !== 1'b1) begin bad++; $display("[TB] FAIL rmid_done: got %b want 1", dev_done); end
    next_cycle;
    dev_req = 1'b0; mem_rdata = '0;
    sample;
    total++; if (dev_rdata !== 32'h3C3C3C3C) begin bad++; $display("[TB] FAIL rmid_rdata_after: got %h want 3c3c3c3c", dev_rdata); end
`ifdef DMEM_ARB_PERF_EN
    total++; if (perf_gnt !== 32'd1) begin bad++; $display("[TB] FAIL perf_dev_grants: got %0d want 1", perf_gnt); end
`endif
  endtask

  task automatic test_lat1;
    next_cycle;
    cpu1_req = 1'b1; cpu1_addr = 32'h20;
    sample;
    total++; if (mem1_en !== 1'b1 || stall1 !== 1'b1 || mem1_addr !== 32'h20) begin bad++; $display("[TB] FAIL lat1_issue: got en=%b stall=%b addr=%h want 1 1 00000020", mem1_en, stall1, mem1_addr); end
    next_cycle;
    mem1_rdata = 32'hCAFEF00D;
    sample;
    total++; if (stall1 !== 1'b0 || cpu1_rdata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL lat1_done: got stall=%b rdata=%h want 0 cafef00d", stall1, cpu1_rdata); end
    next_cycle;
    cpu1_req = 1'b0; mem1_rdata = '0;
    sample;
    total++; if (cpu1_rdata !== 32'hCAFEF00D || mem1_en !== 1'b0) begin bad++; $display("[TB] FAIL lat1_hold: got rdata=%h en=%b want cafef00d 0", cpu1_rdata, mem1_en); end
`ifdef DMEM_ARB_PERF_EN
    total++; if (perf1_stall !== 32'd1) begin bad++; $display("[TB] FAIL lat1_perf_stall: got %0d want 1", perf1_stall); end
`endif
  endtask

  initial begin
    test_reset;
    test_cpu_load;
    test_cpu_store;
    test_simultaneous;
    test_starvation;
    test_reset_mid;
    test_lat1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage and one secondary device requester (DMA/peripheral). Sequences each multi-cycle access and holds stall_mem high until the MEM-stage access completes. Sits between the MEM stage, the hazard unit's full-pipeline stall path, and the data memory macro. CPU has priority, bounded by an anti-starvation counter for the device.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from grant (mem_en) to access complete; legal range >= 1
STARVE_MAX, 4, consecutive CPU grants allowed while dev_req is pending before the device is forced through

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  MEM stage has a load or store (memread | memwrite)
cpu_we  in  1  1 = store
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU load data
stall_mem  out  1  full-pipeline stall request
dev_req  in  1  device request
dev_we  in  1  device write
dev_addr  in  ADDR_W  device address
dev_wdata  in  DATA_W  device write data
dev_gnt  out  1  one-cycle pulse: device access issued
dev_done  out  1  one-cycle pulse: device access complete
dev_rdata  out  DATA_W  device read data, held until next dev_done
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, valid with mem_en
mem_addr  out  ADDR_W  memory address, valid with mem_en
mem_wdata  out  DATA_W  memory write data, valid with mem_en
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (async, rst_n=0): state IDLE, counters 0; all outputs 0, incl. cpu_rdata, dev_rdata, stall_mem.
- States: IDLE, BUSY_CPU, BUSY_DEV.
- IDLE, no requests: mem_en=0.
- IDLE, arbitration is combinational in the same cycle. Grant CPU if cpu_req && !(dev_req && starve_cnt==STARVE_MAX). Otherwise grant the device if dev_req.
- Grant cycle: mem_en=1; mem_we/addr/wdata driven from the winner's inputs. Latency counter loads MEM_LAT. Next state BUSY_CPU or BUSY_DEV. Device grant also pulses dev_gnt.
- BUSY_*: mem_en=0. Counter decrements each cycle. Access completes on the cycle the counter reaches 1, i.e. exactly MEM_LAT cycles after the grant cycle. Next state is IDLE. No new grant during BUSY.
- CPU completion cycle: cpu_rdata = mem_rdata (bypass), and the value is registered. Outside completion, cpu_rdata holds the last registered value.
- stall_mem = cpu_req && !(state==BUSY_CPU && completing). The CPU sees stall for MEM_LAT cycles and the pipeline advances on the completion edge.
- A CPU request waiting behind a device access stalls through the device access, then is granted in the following IDLE cycle.
- Device completion cycle: dev_done=1, dev_rdata <= mem_rdata (writes also update it; value unspecified for writes).
- starve_cnt (width clog2(STARVE_MAX+1)):
  - +1 on a CPU grant while dev_req=1.
  - Cleared on device grant.
  - Cleared in IDLE when dev_req=0.
  - Saturates at STARVE_MAX.
- Requesters hold req and fields stable until done. cpu_req completing is consumed: any cpu_req seen in the next IDLE cycle is a new access.
- dev_req dropped after grant: access still completes and dev_done still pulses.
- Writes take the full MEM_LAT latency, same as reads.
- Reset mid-access: the access is abandoned, no done pulse, and the FSM is IDLE after release.

Optional Feature:
Macro DMEM_ARB_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_dev_grants[31:0].
  - perf_stall_cycles counts cycles with stall_mem=1.
  - perf_dev_grants counts dev_gnt pulses.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- CPU load, MEM_LAT=2: cpu_req=1, addr 0x100, mem_rdata=0xDEADBEEF at completion. Expect mem_en at cycle 0, stall_mem=1 at cycles 0–1, stall_mem=0 at cycle 2 with cpu_rdata=0xDEADBEEF.
- CPU store: addr 0x40, wdata 0x12345678. Expect a single mem_en cycle with mem_we=1, mem_addr=0x40, mem_wdata=0x12345678, and stall for 2 cycles.
- Simultaneous requests, starve_cnt=0: CPU wins, device gets dev_gnt on the first IDLE cycle after CPU completion while cpu_req=0.
- Starvation, STARVE_MAX=4: cpu_req held back-to-back with dev_req=1. After 4 CPU grants, the 5th grant goes to the device (dev_gnt=1) and starve_cnt returns to 0.
- Reset mid-access: assert rst_n=0 one cycle after a device grant. Expect outputs 0 immediately, no dev_done, and a new request granted normally after release.
- MEM_LAT=1 build: a CPU load stalls exactly 1 cycle and rdata is valid in the completion cycle. With DMEM_ARB_PERF_EN defined, perf_stall_cycles=1.
